// File: rtl/in256_out1536_pack.sv
`timescale 1ns/1ps
// Packs a 256-bit AXI-Stream into 1536-bit words (six beats per word), with
// tlast-driven early close, zero padding, per-lane keep and an output holding register.
module in256_out1536_pack #(
  parameter int IN_W  = 256,
  parameter int RATIO = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_W-1:0]       s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [IN_W*RATIO-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [RATIO-1:0]      m_axis_tkeep,
  output logic                  m_axis_tlast
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int ACC_W = IN_W * (RATIO - 1);
  localparam int CNT_W = $clog2(RATIO);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic [RATIO-2:0] r_acc_keep;
  logic [OUT_W-1:0] r_m_data;
  logic [RATIO-1:0] r_m_keep;
  logic             r_m_last;
  logic             r_m_valid;

  logic             w_out_free;
  logic             w_accept;
  logic             w_close;
  logic [OUT_W-1:0] w_word;
  logic [RATIO-1:0] w_keep;

  assign w_out_free = !r_m_valid || m_axis_tready;
  assign w_accept   = s_axis_tvalid && w_out_free;
  assign w_close    = w_accept && ((r_cnt == LAST_LANE) || s_axis_tlast);

  // Accumulator lanes at or above r_cnt are always zero, so the closing beat can
  // simply overwrite lane r_cnt and the lanes above stay as zero padding.
  always_comb begin
    w_word                       = '0;
    w_word[ACC_W-1:0]            = r_acc;
    w_word[r_cnt*IN_W +: IN_W]   = s_axis_tdata;
    w_keep                       = {1'b0, r_acc_keep};
    w_keep[r_cnt]                = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_acc_keep <= '0;
      r_m_data   <= '0;
      r_m_keep   <= '0;
      r_m_last   <= 1'b0;
      r_m_valid  <= 1'b0;
    end else if (w_close) begin
      r_m_data   <= w_word;
      r_m_keep   <= w_keep;
      r_m_last   <= s_axis_tlast;
      r_m_valid  <= 1'b1;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_acc_keep <= '0;
    end else begin
      if (r_m_valid && m_axis_tready) begin
        r_m_valid <= 1'b0;
      end
      if (w_accept) begin
        r_acc[r_cnt*IN_W +: IN_W] <= s_axis_tdata;
        r_acc_keep[r_cnt]         <= 1'b1;
        r_cnt                     <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign s_axis_tready = w_out_free;
  assign m_axis_tdata  = r_m_data;
  assign m_axis_tkeep  = r_m_keep;
  assign m_axis_tlast  = r_m_last;
  assign m_axis_tvalid = r_m_valid;

endmodule

// File: tb/tb_in256_out1536_pack.sv
`timescale 1ns/1ps
// Bench for in256_out1536_pack: randomized beats scored against a queue-based
// model of word packing (beats grouped by count or tlast, keep = lanes present).
module tb_in256_out1536_pack;

  logic          clk = 1'b0;
  logic          rst;
  logic [255:0]  s_data;
  logic          s_valid;
  logic          s_ready;
  logic          s_last;
  logic [1535:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [5:0]    m_keep;
  logic          m_last;

  in256_out1536_pack #(.IN_W(256), .RATIO(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_data),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .s_axis_tlast  (s_last),
    .m_axis_tdata  (m_data),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .m_axis_tkeep  (m_keep),
    .m_axis_tlast  (m_last)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int stalls;
  bit done;

  logic [1535:0] obs_d[$], exp_d[$];
  logic [5:0]    obs_k[$], exp_k[$];
  logic          obs_l[$], exp_l[$];
  int            obs_c[$];
  logic [255:0]  lanes[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output handshake; inputs only move just after rising edges.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      obs_d.push_back(m_data);
      obs_k.push_back(m_keep);
      obs_l.push_back(m_last);
      obs_c.push_back(cyc);
    end
  end

  // Reference: collect accepted beats; a word closes on tlast or when six are held.
  function automatic void model_push(input logic [255:0] d, input logic l);
    logic [1535:0] w;
    int n;
    lanes.push_back(d);
    if (l || lanes.size() == 6) begin
      w = '0;
      n = lanes.size();
      for (int i = 0; i < n; i++) w[i*256 +: 256] = lanes[i];
      exp_d.push_back(w);
      exp_k.push_back(6'((1 << n) - 1));
      exp_l.push_back(l);
      lanes.delete();
    end
  endfunction

  function automatic logic [255:0] rand_beat();
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic clear_q();
    obs_d.delete(); obs_k.delete(); obs_l.delete(); obs_c.delete();
    exp_d.delete(); exp_k.delete(); exp_l.delete();
  endtask

  // Called and returns at rising edge + 1.
  task automatic send_beat(input logic [255:0] d, input logic l);
    int  waited;
    bit  taken;
    s_valid = 1'b1; s_data = d; s_last = l;
    waited = 0; taken = 1'b0;
    while (!taken) begin
      @(negedge clk);
      taken = s_ready;
      if (!s_ready) stalls++;
      @(posedge clk); #1;
      if (!taken) begin
        waited++;
        if (waited > 500) begin
          total++; bad++;
          $display("FAIL send_timeout: beat not accepted after %0d cycles, expected acceptance", waited);
          s_valid = 1'b0;
          return;
        end
      end
    end
    model_push(d, l);
  endtask

  task automatic drain();
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_beat(rand_beat(), 1'b0);
    s_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    total += 5;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b, expected 0", m_valid); end
    if (m_data !== '0) begin bad++; $display("FAIL reset_data: got lane0=%h, expected 0", m_data[255:0]); end
    if (m_keep !== 6'h00) begin bad++; $display("FAIL reset_keep: got %h, expected 00", m_keep); end
    if (m_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b, expected 0", m_last); end
    if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_sready: got %b, expected 1", s_ready); end
    @(posedge clk); #1;
    rst = 1'b0; lanes.delete(); clear_q(); m_ready = 1'b1;
    // two partial beats, then a reset that must discard them
    send_beat(rand_beat(), 1'b0);
    send_beat(rand_beat(), 1'b0);
    s_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; lanes.delete(); clear_q();
    for (int i = 0; i < 6; i++) send_beat(256'(i + 1), 1'b0);
    drain();
    total++;
    if (obs_d.size() != 1) begin bad++; $display("FAIL reset_count: got %0d words, expected 1", obs_d.size()); end
    if (obs_d.size() >= 1) begin
      for (int k = 0; k < 6; k++) begin
        total++;
        if (obs_d[0][k*256 +: 256] !== 256'(k + 1)) begin
          bad++; $display("FAIL reset_lane%0d: got %h, expected %0d", k, obs_d[0][k*256 +: 256], k + 1);
        end
      end
      total += 2;
      if (obs_k[0] !== 6'h3F) begin bad++; $display("FAIL reset_word_keep: got %h, expected 3f", obs_k[0]); end
      if (obs_l[0] !== 1'b0) begin bad++; $display("FAIL reset_word_last: got %b, expected 0", obs_l[0]); end
    end
  endtask

  task automatic test_streaming();
    clear_q(); stalls = 0; m_ready = 1'b1;
    for (int i = 0; i < 60; i++) send_beat(256'(i + 1000), 1'b0);
    drain();
    total += 2;
    if (stalls != 0) begin bad++; $display("FAIL stream_stall: got %0d stalled cycles, expected 0", stalls); end
    if (obs_d.size() != 10) begin bad++; $display("FAIL stream_count: got %0d words, expected 10", obs_d.size()); end
    for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
      total++;
      if (obs_d[i] !== exp_d[i] || obs_k[i] !== exp_k[i] || obs_l[i] !== exp_l[i]) begin
        bad++;
        $display("FAIL stream_word%0d: got keep=%h last=%b lane0=%h, expected keep=%h last=%b lane0=%h",
                 i, obs_k[i], obs_l[i], obs_d[i][255:0], exp_k[i], exp_l[i], exp_d[i][255:0]);
      end
    end
    for (int i = 1; i < obs_c.size(); i++) begin
      total++;
      if (obs_c[i] - obs_c[i-1] != 6) begin
        bad++; $display("FAIL stream_spacing%0d: got %0d cycles, expected 6", i, obs_c[i] - obs_c[i-1]);
      end
    end
  endtask

  task automatic test_partial_flush();
    logic [255:0] a, b, c, d;
    clear_q(); m_ready = 1'b1;
    a = rand_beat(); b = rand_beat(); c = rand_beat(); d = rand_beat();
    send_beat(a, 1'b0); send_beat(b, 1'b0); send_beat(c, 1'b1);
    send_beat(d, 1'b0); send_beat(rand_beat(), 1'b1);
    send_beat(rand_beat(), 1'b1);
    for (int i = 0; i < 6; i++) send_beat(rand_beat(), i == 5);
    drain();
    total++;
    if (obs_d.size() != 4) begin bad++; $display("FAIL flush_count: got %0d words, expected 4", obs_d.size()); end
    if (obs_d.size() == 4) begin
      total += 9;
      if (obs_k[0] !== 6'b000111) begin bad++; $display("FAIL flush_keep: got %b, expected 000111", obs_k[0]); end
      if (obs_l[0] !== 1'b1) begin bad++; $display("FAIL flush_last: got %b, expected 1", obs_l[0]); end
      if (obs_d[0][767:0] !== {c, b, a}) begin bad++; $display("FAIL flush_lanes: got lane0=%h, expected %h", obs_d[0][255:0], a); end
      if (obs_d[0][1535:768] !== '0) begin bad++; $display("FAIL flush_pad: got lane3=%h, expected 0", obs_d[0][1023:768]); end
      if (obs_d[1][255:0] !== d) begin bad++; $display("FAIL flush_next_lane0: got %h, expected %h", obs_d[1][255:0], d); end
      if (obs_k[2] !== 6'b000001) begin bad++; $display("FAIL single_keep: got %b, expected 000001", obs_k[2]); end
      if (obs_l[2] !== 1'b1 || obs_d[2][1535:256] !== '0) begin bad++; $display("FAIL single_last_pad: got last=%b, expected 1 with zero lanes 1..5", obs_l[2]); end
      if (obs_k[3] !== 6'h3F) begin bad++; $display("FAIL lane5_keep: got %h, expected 3f", obs_k[3]); end
      if (obs_l[3] !== 1'b1) begin bad++; $display("FAIL lane5_last: got %b, expected 1", obs_l[3]); end
    end
    for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
      total++;
      if (obs_d[i] !== exp_d[i] || obs_k[i] !== exp_k[i] || obs_l[i] !== exp_l[i]) begin
        bad++;
        $display("FAIL flush_word%0d: got keep=%h last=%b lane0=%h, expected keep=%h last=%b lane0=%h",
                 i, obs_k[i], obs_l[i], obs_d[i][255:0], exp_k[i], exp_l[i], exp_d[i][255:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1535:0] held;
    clear_q(); m_ready = 1'b1; done = 1'b0;
    fork
      begin
        for (int i = 0; i < 18; i++) send_beat(rand_beat(), 1'b0);
        s_valid = 1'b0;
        done = 1'b1;
      end
      begin
        int w;
        w = 0;
        while (!m_valid && w < 200) begin @(posedge clk); #1; w++; end
        m_ready = 1'b0;
        held = m_data;
        repeat (10) begin
          @(negedge clk);
          total += 3;
          if (m_data !== held) begin bad++; $display("FAIL bp_stable: got lane0=%h, expected %h", m_data[255:0], held[255:0]); end
          if (s_ready !== 1'b0) begin bad++; $display("FAIL bp_sready: got %b, expected 0", s_ready); end
          if (m_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b, expected 1", m_valid); end
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
      end
    join
    drain();
    total++;
    if (obs_d.size() != 3) begin bad++; $display("FAIL bp_count: got %0d words, expected 3", obs_d.size()); end
    for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
      total++;
      if (obs_d[i] !== exp_d[i] || obs_k[i] !== exp_k[i] || obs_l[i] !== exp_l[i]) begin
        bad++;
        $display("FAIL bp_word%0d: got keep=%h last=%b lane0=%h, expected keep=%h last=%b lane0=%h",
                 i, obs_k[i], obs_l[i], obs_d[i][255:0], exp_k[i], exp_l[i], exp_d[i][255:0]);
      end
    end
  endtask

  task automatic test_simultaneous();
    clear_q(); m_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_beat(rand_beat(), 1'b1);
    drain();
    total++;
    if (obs_d.size() != 8) begin bad++; $display("FAIL simul_count: got %0d words, expected 8", obs_d.size()); end
    for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
      total++;
      if (obs_d[i] !== exp_d[i] || obs_k[i] !== exp_k[i] || obs_l[i] !== exp_l[i]) begin
        bad++;
        $display("FAIL simul_word%0d: got keep=%h last=%b lane0=%h, expected keep=%h last=%b lane0=%h",
                 i, obs_k[i], obs_l[i], obs_d[i][255:0], exp_k[i], exp_l[i], exp_d[i][255:0]);
      end
    end
    for (int i = 1; i < obs_c.size(); i++) begin
      total++;
      if (obs_c[i] - obs_c[i-1] != 1) begin
        bad++; $display("FAIL simul_spacing%0d: got %0d cycles, expected 1", i, obs_c[i] - obs_c[i-1]);
      end
    end
  endtask

  task automatic test_random();
    clear_q(); done = 1'b0;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          if ($urandom_range(0, 4) == 0) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
          end
          send_beat(rand_beat(), ($urandom_range(0, 3) == 0) || (i == 79));
        end
        s_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          m_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
    drain();
    total++;
    if (obs_d.size() != exp_d.size()) begin bad++; $display("FAIL rand_count: got %0d words, expected %0d", obs_d.size(), exp_d.size()); end
    for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
      total++;
      if (obs_d[i] !== exp_d[i] || obs_k[i] !== exp_k[i] || obs_l[i] !== exp_l[i]) begin
        bad++;
        $display("FAIL rand_word%0d: got keep=%h last=%b lane0=%h, expected keep=%h last=%b lane0=%h",
                 i, obs_k[i], obs_l[i], obs_d[i][255:0], exp_k[i], exp_l[i], exp_d[i][255:0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1; stalls = 0; done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_streaming();
    test_partial_flush();
    test_backpressure();
    test_simultaneous();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
